axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 26, address width; DATA_WIDTH, default 32, data width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- init_end  in  1  memory initialisation complete.
- sN_arvalid  in  1  read request from requester N (N=0,1).
- sN_arready  out  1  request accepted.
- sN_araddr  in  ADDR_WIDTH  start address.
- sN_arlen  in  8  AXI burst length (beats-1).
- sN_rvalid  out  1  read data valid.
- sN_rready  in  1  read data accept.
- sN_rdata  out  DATA_WIDTH  read data.
- sN_rlast  out  1  last beat.
- m_arvalid, m_araddr, m_arlen  out  1/ADDR_WIDTH/8  shared AR channel.
- m_arready  in  1  shared AR channel ready.
- m_rvalid, m_rdata, m_rlast  in  1/DATA_WIDTH/1  shared R channel.
- m_rready  out  1  shared R channel ready.
- grant  out  1  index of the current owner.
- busy  out  1  a transaction is in progress.
- err  out  1  sticky protocol error flag.

Function
REQ-003 SHALL implement an FSM with three states: IDLE, ADDR and DATA.
REQ-004 IDLE: no grant SHALL be issued while init_end=0.
REQ-005 IDLE: when init_end=1 and any sN_arvalid=1, the block SHALL select a requester and, on the same clock edge:
- latch sN_araddr/sN_arlen into m_araddr/m_arlen;
- set m_arvalid=1;
- set grant=N;
- load the beat counter with arlen;
- enter ADDR.
REQ-006 sN_arready SHALL be a one-cycle pulse, registered, asserted in the first ADDR cycle for the granted N only.
REQ-007 Round-robin: when both requesters are requesting, the block SHALL choose the one not granted last; after reset, requester 0 wins.
REQ-008 ADDR: m_arvalid, m_araddr and m_arlen SHALL hold stable until m_arready=1, then m_arvalid SHALL go 0 and the FSM SHALL enter DATA.
REQ-009 DATA routing for the granted N, combinational:
- sN_rvalid=m_rvalid, sN_rdata=m_rdata, sN_rlast=m_rlast, m_rready=sN_rready.
- The non-granted requester SHALL see rvalid=0 and rlast=0; its rdata SHALL be m_rdata.
REQ-010 m_rready SHALL be 0 outside DATA.
REQ-011 Beat counting: each beat where m_rvalid&m_rready=1 SHALL decrement the counter.
REQ-012 A transfer SHALL end on a beat where m_rvalid&m_rready&m_rlast=1: return to IDLE and record grant as the last-granted requester.
REQ-013 If m_rlast arrives while the counter is not 0, or the counter is 0 with m_rlast=0, err SHALL be set to 1 and SHALL remain set until reset; in the first case the transfer still ends on m_rlast.
REQ-014 Requests arriving during ADDR/DATA SHALL wait (sN_arready=0) and need not be withdrawn.
REQ-015 busy SHALL be 1 in ADDR and DATA and 0 in IDLE.
REQ-016 One transaction SHALL be outstanding at a time; there is no request pipelining.
REQ-017 Minimum gap between back-to-back grants SHALL be 1 IDLE cycle.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL reset to: state=IDLE, m_arvalid=0, m_araddr=0, m_arlen=0, sN_arready=0, grant=0, last-granted pointer=1, counter=0, err=0.
REQ-019 A reset mid-burst SHALL abandon the transaction without completing it; beats remaining on the R channel afterwards SHALL be ignored (m_rready=0).

Structure
REQ-020 Shared package axi_rd_arb_pkg SHALL hold: the state encoding constants (IDLE/ADDR/DATA), the requester count (2) and the arlen width (8).
REQ-021 Round-robin selection SHALL be a sub-module rr_arb2: combinational, inputs req[1:0] and last, outputs valid and idx.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- init_end=0 with s0_arvalid=1 -> no s0_arready and m_arvalid=0 for 20 cycles; after init_end=1 -> grant within 1 cycle.
- s0 requests addr=0x100, arlen=7; m_arready delayed 3 cycles -> m_araddr=0x100, m_arlen=7 stable; 8 beats reach s0 only; busy falls the cycle after rlast.
- Both requesters held requesting continuously for 4 transactions -> grant sequence 0,1,0,1.
- s1_rready toggled 1/0 during a burst -> m_rready mirrors it; no beat lost or duplicated; data order preserved.
- arlen=3 with m_rlast sent on the 2nd beat -> err=1 and stays 1; FSM returns to IDLE; next request still served.
- rst_n pulsed low in DATA after 2 of 8 beats -> all outputs at reset values the next cycle; a new s1 request completes normally.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the two-requester AXI read arbiter.
package axi_rd_arb_pkg;

  localparam int unsigned NumReq     = 2;
  localparam int unsigned ArlenWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates two AXI read requesters onto one AR/R channel, one burst at a time.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [ArlenWidth-1:0] s0_arlen,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [ArlenWidth-1:0] s1_arlen,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [ArlenWidth-1:0] m_arlen,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  output logic                  m_rready,
  output logic                  grant,
  output logic                  busy,
  output logic                  err
);

  state_e                  state_q;
  logic [ArlenWidth-1:0]   cnt_q;
  logic                    last_q;
  logic [NumReq-1:0]       arready_q;
  logic                    m_arvalid_q;
  logic [ADDR_WIDTH-1:0]   m_araddr_q;
  logic [ArlenWidth-1:0]   m_arlen_q;
  logic                    grant_q;
  logic                    err_q;
  logic                    sel_valid;
  logic                    sel_idx;
  logic                    beat;

  rr_arb2 u_rr_arb2 (
    .req   ({s1_arvalid, s0_arvalid}),
    .last  (last_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign beat = (state_q == StData) && m_rvalid && m_rready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      arready_q   <= '0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      grant_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      arready_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (init_end && sel_valid) begin
            m_araddr_q  <= sel_idx ? s1_araddr : s0_araddr;
            m_arlen_q   <= sel_idx ? s1_arlen : s0_arlen;
            cnt_q       <= sel_idx ? s1_arlen : s0_arlen;
            m_arvalid_q <= 1'b1;
            grant_q     <= sel_idx;
            arready_q   <= sel_idx ? 2'b10 : 2'b01;
            state_q     <= StAddr;
          end
        end
        StAddr: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (beat) begin
            // Counter saturates at zero; errors are judged on the pre-beat count.
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (m_rlast) begin
              if (cnt_q != '0) err_q <= 1'b1;
              last_q  <= grant_q;
              state_q <= StIdle;
            end else if (cnt_q == '0) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s0_rvalid = 1'b0;
    s1_rvalid = 1'b0;
    s0_rlast  = 1'b0;
    s1_rlast  = 1'b0;
    m_rready  = 1'b0;
    if (state_q == StData) begin
      if (grant_q) begin
        s1_rvalid = m_rvalid;
        s1_rlast  = m_rlast;
        m_rready  = s1_rready;
      end else begin
        s0_rvalid = m_rvalid;
        s0_rlast  = m_rlast;
        m_rready  = s0_rready;
      end
    end
  end

  assign s0_rdata   = m_rdata;
  assign s1_rdata   = m_rdata;
  assign s0_arready = arready_q[0];
  assign s1_arready = arready_q[1];
  assign m_arvalid  = m_arvalid_q;
  assign m_araddr   = m_araddr_q;
  assign m_arlen    = m_arlen_q;
  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;

endmodule
